// File: rtl/glitc_config_controller_if.sv
`default_nettype none
// ==========================================================================
// Module   : glitc_config_controller_if
// Brief    : Wishbone slave bus bundle for the GLITC configuration controller.
// Revision : 1.0
// ==========================================================================
interface glitc_config_controller_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [3:0]  adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;
   logic        rty_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      input  dat_o, ack_o, err_o, rty_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      output dat_o, ack_o, err_o, rty_o
   );
endinterface
`default_nettype wire

// File: rtl/glitc_config_controller.sv
`default_nettype none
// ==========================================================================
// Module   : glitc_config_controller
// Brief    : Per-GLITC PROGRAM_B/INIT_B/DONE sequencer with Wishbone control.
// Revision : 1.0
// ==========================================================================
module glitc_config_controller #(
   parameter int PROG_CYCLES  = 64,
   parameter int INIT_TIMEOUT = 65536,
   parameter int NUM_GLITC    = 4
) (
   input  wire logic                 clk_i,
   input  wire logic                 rst_i,
   glitc_config_controller_if.slave  wb,
   output logic [NUM_GLITC-1:0]      GPROGRAM_B,
   input  wire logic [NUM_GLITC-1:0] GINIT_B,
   input  wire logic [NUM_GLITC-1:0] GDONE,
   output logic [NUM_GLITC-1:0]      gready_o
);

   localparam int c_CNT_MAX = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
   localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
   localparam logic [c_CNT_W-1:0] c_PROG_LOAD = c_CNT_W'(PROG_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_INIT_LOAD = c_CNT_W'(INIT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_UNCONFIG  = 3'd0,
      ST_PROG      = 3'd1,
      ST_WAIT_INIT = 3'd2,
      ST_LOAD      = 3'd3,
      ST_READY     = 3'd4,
      ST_ERROR     = 3'd5
   } state_t;

   logic [NUM_GLITC-1:0]   r_init_meta, r_init_s;
   logic [NUM_GLITC-1:0]   r_done_meta, r_done_s;
   logic                   r_ack;
   logic [31:0]            r_dat;
   logic [NUM_GLITC-1:0]   r_prog_req;
   logic                   w_req;
   logic [31:0]            w_rd_data;
   logic [NUM_GLITC-1:0]   w_error;
   logic [3*NUM_GLITC-1:0] w_state_codes;
   logic                   w_unused;

   // GINIT_B and GDONE are asynchronous to clk_i
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_init_meta <= '0;
         r_init_s    <= '0;
         r_done_meta <= '0;
         r_done_s    <= '0;
      end else begin
         r_init_meta <= GINIT_B;
         r_init_s    <= r_init_meta;
         r_done_meta <= GDONE;
         r_done_s    <= r_done_meta;
      end
   end

   assign w_req = wb.cyc_i & wb.stb_i & ~r_ack;

   always_comb begin
      w_rd_data = '0;
      case (wb.adr_i[3:2])
         2'd1: begin
            w_rd_data[0  +: NUM_GLITC] = gready_o;
            w_rd_data[4  +: NUM_GLITC] = w_error;
            w_rd_data[8  +: NUM_GLITC] = r_done_s;
            w_rd_data[12 +: NUM_GLITC] = r_init_s;
         end
         2'd2:    w_rd_data[3*NUM_GLITC-1:0] = w_state_codes;
         default: w_rd_data = '0;
      endcase
   end

   // r_prog_req is only non-zero during the ack cycle, so the FSMs enter
   // PROG on the edge that ends the ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ack      <= 1'b0;
         r_dat      <= '0;
         r_prog_req <= '0;
      end else begin
         r_ack      <= w_req;
         r_dat      <= w_req ? w_rd_data : '0;
         r_prog_req <= (w_req && wb.we_i && (wb.adr_i[3:2] == 2'd0))
                       ? wb.dat_i[NUM_GLITC-1:0] : '0;
      end
   end

   assign wb.ack_o = r_ack;
   assign wb.dat_o = r_dat;
   assign wb.err_o = 1'b0;
   assign wb.rty_o = 1'b0;

   assign w_unused = &{1'b0, wb.sel_i, wb.adr_i[1:0], wb.dat_i[31:NUM_GLITC]};

   for (genvar g = 0; g < NUM_GLITC; g++) begin : g_glitc
      state_t               r_state, w_state_nxt;
      logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
      logic                 r_prog_b;
      logic                 r_gready;

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         if (r_prog_req[g]) begin
            w_state_nxt = ST_PROG;
            w_cnt_nxt   = c_PROG_LOAD;
         end else begin
            case (r_state)
               ST_UNCONFIG: begin
                  if (r_done_s[g]) w_state_nxt = ST_READY;
               end
               ST_PROG: begin
                  if (r_cnt == '0) begin
                     w_state_nxt = ST_WAIT_INIT;
                     w_cnt_nxt   = c_INIT_LOAD;
                  end else begin
                     w_cnt_nxt = r_cnt - 1'b1;
                  end
               end
               ST_WAIT_INIT: begin
                  if (r_init_s[g])       w_state_nxt = ST_LOAD;
                  else if (r_cnt == '0)  w_state_nxt = ST_ERROR;
                  else                   w_cnt_nxt   = r_cnt - 1'b1;
               end
               // DONE wins over a simultaneous INIT_B drop
               ST_LOAD: begin
                  if (r_done_s[g])       w_state_nxt = ST_READY;
                  else if (!r_init_s[g]) w_state_nxt = ST_ERROR;
               end
               ST_READY: begin
                  if (!r_done_s[g]) w_state_nxt = ST_UNCONFIG;
               end
               ST_ERROR: w_state_nxt = ST_ERROR;
               default:  w_state_nxt = ST_UNCONFIG;
            endcase
         end
      end

      // Outputs register the next state so they track the state register exactly.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_state  <= ST_UNCONFIG;
            r_cnt    <= '0;
            r_prog_b <= 1'b1;
            r_gready <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prog_b <= (w_state_nxt != ST_PROG);
            r_gready <= (w_state_nxt == ST_READY);
         end
      end

      assign GPROGRAM_B[g]          = r_prog_b;
      assign gready_o[g]            = r_gready;
      assign w_error[g]             = (r_state == ST_ERROR);
      assign w_state_codes[3*g +: 3] = r_state;
   end

endmodule
`default_nettype wire

// File: tb/tb_glitc_config_controller.sv
`default_nettype none
// ==========================================================================
// Module   : tb_glitc_config_controller
// Brief    : Directed bench with a deadline-based behavioural model.
// Revision : 1.0
// ==========================================================================
module tb_glitc_config_controller;

   localparam int M_UNC = 0, M_PROG = 1, M_WAIT = 2, M_LOAD = 3, M_READY = 4, M_ERR = 5;
   localparam longint c_PROG_LEN = 64;
   localparam longint c_INIT_LEN = 65536;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] GINIT_B = 4'h0;
   logic [3:0] GDONE = 4'h0;
   logic [3:0] GPROGRAM_B;
   logic [3:0] gready_o;

   int n_cmp = 0;
   int n_bad = 0;

   glitc_config_controller_if wb ();

   glitc_config_controller dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wb         (wb),
      .GPROGRAM_B (GPROGRAM_B),
      .GINIT_B    (GINIT_B),
      .GDONE      (GDONE),
      .gready_o   (gready_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: each GLITC is a mode plus an absolute deadline (edge index)
   int         m_mode [4];
   longint     m_dl   [4];
   logic [3:0] m_i1 = '0, m_i2 = '0, m_d1 = '0, m_d2 = '0;
   logic       m_ack = 1'b0;
   logic [31:0] m_dat = '0;
   logic [3:0] m_pend = '0;
   longint     ncyc = 0;
   bit         m_live = 1'b0;

   function automatic logic [31:0] m_read(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      if (a[3:2] == 2'd1) begin
         for (int g = 0; g < 4; g++) begin
            r[g]      = (m_mode[g] == M_READY);
            r[4 + g]  = (m_mode[g] == M_ERR);
         end
         r[11:8]  = m_d2;
         r[15:12] = m_i2;
      end else if (a[3:2] == 2'd2) begin
         for (int g = 0; g < 4; g++) r += 32'(m_mode[g]) << (3 * g);
      end
      return r;
   endfunction

   always @(posedge clk) begin : p_model
      int nm;
      longint nd;
      logic [3:0] go;
      if (rst) begin
         for (int g = 0; g < 4; g++) begin
            m_mode[g] <= M_UNC;
            m_dl[g]   <= 0;
         end
         m_ack <= 1'b0; m_dat <= '0; m_pend <= '0;
         m_i1 <= '0; m_i2 <= '0; m_d1 <= '0; m_d2 <= '0;
      end else begin
         go = m_ack ? m_pend : 4'h0;
         for (int g = 0; g < 4; g++) begin
            nm = m_mode[g];
            nd = m_dl[g];
            if (go[g]) begin
               nm = M_PROG;
               nd = ncyc + c_PROG_LEN;
            end else if (m_mode[g] == M_UNC && m_d2[g]) begin
               nm = M_READY;
            end else if (m_mode[g] == M_PROG && ncyc == m_dl[g]) begin
               nm = M_WAIT;
               nd = ncyc + c_INIT_LEN;
            end else if (m_mode[g] == M_WAIT) begin
               if (m_i2[g])              nm = M_LOAD;
               else if (ncyc == m_dl[g]) nm = M_ERR;
            end else if (m_mode[g] == M_LOAD) begin
               if (m_d2[g])       nm = M_READY;
               else if (!m_i2[g]) nm = M_ERR;
            end else if (m_mode[g] == M_READY && !m_d2[g]) begin
               nm = M_UNC;
            end
            m_mode[g] <= nm;
            m_dl[g]   <= nd;
         end
         if (wb.cyc_i && wb.stb_i && !m_ack) begin
            m_ack  <= 1'b1;
            m_dat  <= m_read(wb.adr_i);
            m_pend <= (wb.we_i && wb.adr_i[3:2] == 2'd0) ? wb.dat_i[3:0] : 4'h0;
         end else begin
            m_ack <= 1'b0; m_dat <= '0; m_pend <= '0;
         end
         m_i1 <= GINIT_B; m_i2 <= m_i1;
         m_d1 <= GDONE;   m_d2 <= m_d1;
      end
      ncyc   <= ncyc + 1;
      m_live <= 1'b1;
   end

   always @(negedge clk) begin : p_compare
      logic [3:0] epb, erdy;
      if (m_live) begin
         for (int g = 0; g < 4; g++) begin
            epb[g]  = (m_mode[g] != M_PROG);
            erdy[g] = (m_mode[g] == M_READY);
         end
         chk("GPROGRAM_B", GPROGRAM_B, epb);
         chk("gready_o", gready_o, erdy);
         chk("ack_o", wb.ack_o, m_ack);
         chk("err_rty", {wb.err_o, wb.rty_o}, 0);
         if (m_ack) chk("dat_o", wb.dat_o, m_dat);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          output logic [31:0] rdat);
      logic got;
      got  = 1'b0;
      rdat = '0;
      wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.adr_i = adr; wb.dat_i = dat;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (wb.ack_o) begin
            got  = 1'b1;
            rdat = wb.dat_o;
         end
      end
      chk("wb_ack_seen", got, 1);
      @(posedge clk);
      #2;
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
   endtask

   initial begin : p_watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin : p_stim
      logic [31:0] rd;
      int k;
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
      wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = 4'hF;

      tick(3); rst = 1'b0; tick(2);
      chk("rst_progb", GPROGRAM_B, 4'hF);
      chk("rst_gready", gready_o, 4'h0);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("rst_state", rd, 32'h000);
      wb_xfer(1'b0, 4'hC, 0, rd); chk("reg3_read", rd, 32'h0);

      // reset with a pre-configured GLITC 2
      rst = 1'b1; GDONE = 4'b0100; tick(3); rst = 1'b0;
      k = 0;
      while (k < 10 && !gready_o[2]) begin @(posedge clk); #1; k++; end
      chk("done_recover_cycles", k, 3);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("recover_state", rd, 32'h100);
      GDONE = 4'h0; tick(5);
      chk("ready_drop_gready", gready_o, 4'h0);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("ready_drop_state", rd, 32'h0);

      // writes that must not program anything
      wb_xfer(1'b1, 4'h8, 32'hFFF, rd);
      wb_xfer(1'b1, 4'h4, 32'hFFFF, rd);
      wb_xfer(1'b1, 4'h0, 32'h10, rd);
      tick(2); chk("noop_progb", GPROGRAM_B, 4'hF);

      // full configuration of GLITC 0
      wb_xfer(1'b1, 4'h0, 32'h1, rd);
      k = 0;
      while (k < 200) begin @(negedge clk); if (GPROGRAM_B[0]) break; k++; end
      chk("prog_low_cycles", k, 64);
      chk("others_untouched", GPROGRAM_B[3:1], 3'b111);
      tick(9); GINIT_B[0] = 1'b1;
      tick(100); GDONE[0] = 1'b1;
      k = 0;
      while (k < 20 && !gready_o[0]) begin @(posedge clk); #1; k++; end
      chk("done_to_ready", k, 3);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("ready_state", rd, 32'h004);
      GDONE[0] = 1'b0; tick(4);
      chk("ready_lost", gready_o[0], 0);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("unconfig_state", rd, 32'h0);
      GINIT_B[0] = 1'b0;

      // CRC error during LOAD on GLITC 1
      wb_xfer(1'b1, 4'h0, 32'h2, rd);
      tick(72); GINIT_B[1] = 1'b1; tick(6);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("load_state", rd, 32'h018);
      GINIT_B[1] = 1'b0; tick(5);
      wb_xfer(1'b0, 4'h4, 0, rd); chk("crc_status", rd, 32'h20);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("crc_state", rd, 32'h028);

      // INIT_B timeout on GLITC 0
      wb_xfer(1'b1, 4'h0, 32'h1, rd);
      tick(64 + 65536 + 5);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("timeout_state", rd, 32'h02D);
      wb_xfer(1'b0, 4'h4, 0, rd); chk("timeout_status", rd, 32'h30);
      chk("timeout_gready", gready_o[0], 0);
      wb_xfer(1'b1, 4'h0, 32'h1, rd);
      chk("reprog_progb", GPROGRAM_B[0], 0);
      wb_xfer(1'b0, 4'h8, 0, rd); chk("reprog_state", rd, 32'h029);

      // bring all four to READY
      GINIT_B = 4'hF; GDONE = 4'hF;
      wb_xfer(1'b1, 4'h0, 32'h2, rd);
      tick(80);
      chk("all_ready", gready_o, 4'hF);

      // program all four, then reset during PROG
      wb_xfer(1'b1, 4'h0, 32'hF, rd);
      chk("ack_next_gready", gready_o, 4'h0);
      chk("all_prog_low", GPROGRAM_B, 4'h0);
      tick(19);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_releases_progb", GPROGRAM_B, 4'hF);
      #1; rst = 1'b0;
      tick(6);
      chk("ready_after_rst", gready_o, 4'hF);

      // held strobe on STATUS
      wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 4'h4;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb.ack_o) begin
            k++;
            chk("held_status", wb.dat_o, 32'hFF0F);
         end
      end
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
      chk("held_acks", k, 3);

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
